// File: rtl/fir_pkg.sv
// fir_pkg: shared FIR accumulator constants and FSM state type.
package fir_pkg;
  localparam int NUM_TAPS  = 29;
  localparam int OUT_SHIFT = 19;
  localparam int PROD_W    = 51;
  localparam int ACC_W     = 56;
  localparam int OUT_W     = 32;
  typedef enum logic {IDLE, ACCUM} fir_state_e;
endpackage

// File: rtl/fir_accum_if.sv
// fir_accum_if: product input stream and rounded output stream of fir_accum.
interface fir_accum_if;
  import fir_pkg::*;
  logic                     prod_vld;
  logic                     prod_first;
  logic                     prod_last;
  logic signed [PROD_W-1:0] prod_i;
  logic signed [PROD_W-1:0] prod_q;
  logic                     PushOut;
  logic signed [OUT_W-1:0]  FI;
  logic signed [OUT_W-1:0]  FQ;
  logic                     tap_err;
  logic                     sat_flag;
  modport master (output prod_vld, prod_first, prod_last, prod_i, prod_q,
                  input PushOut, FI, FQ, tap_err, sat_flag);
  modport slave (input prod_vld, prod_first, prod_last, prod_i, prod_q,
                 output PushOut, FI, FQ, tap_err, sat_flag);
endinterface

// File: rtl/fir_round_sat.sv
// fir_round_sat: round-half-up right shift of a sum into a held 32-bit register.
// FIR_ACCUM_SAT_EN clamps to the signed 32-bit range; otherwise the result wraps.
module fir_round_sat
  import fir_pkg::OUT_W;
#(
  parameter int ACC_W     = fir_pkg::ACC_W,
  parameter int OUT_SHIFT = fir_pkg::OUT_SHIFT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_vld,
  input  logic signed [ACC_W-1:0] i_sum,
  output logic signed [OUT_W-1:0] o_y,
  output logic                    o_sat
);
  localparam logic signed [ACC_W:0] HALF = (ACC_W + 1)'(1) << (OUT_SHIFT - 1);
  logic signed [ACC_W:0]   w_ext;
  logic signed [OUT_W-1:0] w_y;
  logic signed [OUT_W-1:0] r_y;
  logic                    w_clip;
  logic                    r_sat;
  assign w_ext = {i_sum[ACC_W-1], i_sum};
`ifdef FIR_ACCUM_SAT_EN
  logic signed [ACC_W:0] w_r;
  assign w_r    = (w_ext + HALF) >>> OUT_SHIFT;
  assign w_clip = w_r[ACC_W:OUT_W-1] != {(ACC_W - OUT_W + 2){w_r[ACC_W]}};
  assign w_y    = w_clip ? (w_r[ACC_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}})
                         : w_r[OUT_W-1:0];
`else
  assign w_clip = 1'b0;
  assign w_y    = OUT_W'((w_ext + HALF) >>> OUT_SHIFT);
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y   <= '0;
      r_sat <= 1'b0;
    end else begin
      if (i_vld) r_y <= w_y;
      r_sat <= i_vld & w_clip;
    end
  end
  assign o_y   = r_y;
  assign o_sat = r_sat;
endmodule

// File: rtl/fir_accum.sv
// fir_accum: complex FIR tap accumulator with tap-count checking and rounded 32-bit output.
// Optional build macro FIR_ACCUM_SAT_EN enables output saturation and sat_flag.
module fir_accum #(
  parameter int NUM_TAPS  = fir_pkg::NUM_TAPS,
  parameter int OUT_SHIFT = fir_pkg::OUT_SHIFT,
  parameter int ACC_W     = fir_pkg::ACC_W
) (
  input logic        clk,
  input logic        rst,
  fir_accum_if.slave bus
);
  import fir_pkg::PROD_W;
  import fir_pkg::OUT_W;
  import fir_pkg::fir_state_e;
  import fir_pkg::IDLE;
  import fir_pkg::ACCUM;
  localparam int CNT_W = $clog2(NUM_TAPS + 1) + 1;
  fir_state_e              r_state, w_next;
  logic signed [ACC_W-1:0] r_acc_i, r_acc_q, r_fs_i, r_fs_q;
  logic signed [ACC_W-1:0] w_p_i, w_p_q, w_sum_i, w_sum_q;
  logic [CNT_W-1:0]        r_cnt, w_cnt;
  logic                    r_fs_vld, r_push, r_tap_err;
  logic                    w_load, w_add, w_fin, w_err, w_sat_i, w_sat_q;
  logic signed [OUT_W-1:0] w_fi, w_fq;
  assign w_p_i = {{(ACC_W - PROD_W){bus.prod_i[PROD_W-1]}}, bus.prod_i};
  assign w_p_q = {{(ACC_W - PROD_W){bus.prod_q[PROD_W-1]}}, bus.prod_q};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = (bus.prod_vld && bus.prod_last)  ? IDLE  :
             (bus.prod_vld && bus.prod_first) ? ACCUM : r_state;
  end
  // A first tap always restarts the sum, so the final-sum path never depends on acc then.
  always_comb begin
    w_load  = bus.prod_vld & bus.prod_first & ~bus.prod_last;
    w_add   = bus.prod_vld & (r_state == ACCUM) & ~bus.prod_first & ~bus.prod_last;
    w_fin   = bus.prod_vld & bus.prod_last & (bus.prod_first | (r_state == ACCUM));
    w_sum_i = bus.prod_first ? w_p_i : r_acc_i + w_p_i;
    w_sum_q = bus.prod_first ? w_p_q : r_acc_q + w_p_q;
    w_cnt   = bus.prod_first ? CNT_W'(1) : (&r_cnt ? r_cnt : r_cnt + 1'b1);
    w_err   = bus.prod_vld & (((r_state == IDLE) & ~bus.prod_first) |
                              ((r_state == ACCUM) & bus.prod_first) |
                              (w_fin & (w_cnt != CNT_W'(NUM_TAPS))));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_i   <= '0;
      r_acc_q   <= '0;
      r_cnt     <= '0;
      r_fs_i    <= '0;
      r_fs_q    <= '0;
      r_fs_vld  <= 1'b0;
      r_push    <= 1'b0;
      r_tap_err <= 1'b0;
    end else begin
      if (w_load | w_add) begin
        r_acc_i <= w_sum_i;
        r_acc_q <= w_sum_q;
        r_cnt   <= w_cnt;
      end
      if (w_fin) begin
        r_fs_i <= w_sum_i;
        r_fs_q <= w_sum_q;
      end
      r_fs_vld  <= w_fin;
      r_push    <= r_fs_vld;
      r_tap_err <= w_err;
    end
  end
  fir_round_sat #(.ACC_W(ACC_W), .OUT_SHIFT(OUT_SHIFT)) u_rs_i (
    .clk(clk), .rst(rst), .i_vld(r_fs_vld), .i_sum(r_fs_i), .o_y(w_fi), .o_sat(w_sat_i));
  fir_round_sat #(.ACC_W(ACC_W), .OUT_SHIFT(OUT_SHIFT)) u_rs_q (
    .clk(clk), .rst(rst), .i_vld(r_fs_vld), .i_sum(r_fs_q), .o_y(w_fq), .o_sat(w_sat_q));
  assign bus.PushOut  = r_push;
  assign bus.FI       = w_fi;
  assign bus.FQ       = w_fq;
  assign bus.tap_err  = r_tap_err;
  assign bus.sat_flag = w_sat_i | w_sat_q;
endmodule

// File: tb/tb_fir_accum.sv
// tb_fir_accum: directed and randomized checks of fir_accum against a sum-of-products model.
module tb_fir_accum;
  localparam int OUT_SHIFT = 19;
  localparam longint P19 = 64'sd1 <<< 19;
  typedef struct {int c; logic [31:0] i; logic [31:0] q; logic s;} ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  ev_t    push_q[$];
  int     err_q[$];
  longint q_i[$], q_q[$];
  int cyc = 0, last_cyc = 0, checks = 0, failures = 0;
  always #5 clk = ~clk;
  fir_accum_if bus();
  fir_accum dut (.clk(clk), .rst(rst), .bus(bus));
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.PushOut === 1'b1) push_q.push_back('{cyc, bus.FI, bus.FQ, bus.sat_flag});
    if (bus.tap_err === 1'b1) err_q.push_back(cyc);
  end
  function automatic logic [32:0] model(input longint s);
    longint r;
    r = (s + (64'sd1 <<< (OUT_SHIFT - 1))) >>> OUT_SHIFT;
`ifdef FIR_ACCUM_SAT_EN
    if (r > 64'sd2147483647) return {1'b1, 32'h7FFF_FFFF};
    if (r < -64'sd2147483648) return {1'b1, 32'h8000_0000};
`endif
    return {1'b0, r[31:0]};
  endfunction
  function automatic longint qsum(input bit sel);
    longint s = 0;
    foreach (q_i[k]) s += sel ? q_q[k] : q_i[k];
    return s;
  endfunction
  function automatic longint rnd(input int w);
    longint x;
    x = longint'({$urandom, $urandom});
    return x >>> (64 - w);
  endfunction
  task automatic drive(input bit v, input bit f, input bit l, input longint pi, input longint pq);
    @(posedge clk); #1;
    bus.prod_vld = v; bus.prod_first = f; bus.prod_last = l;
    bus.prod_i = pi[50:0]; bus.prod_q = pq[50:0];
    if (v && l) last_cyc = cyc;
  endtask
  task automatic send;
    for (int k = 0; k < q_i.size(); k++) drive(1, k == 0, k == q_i.size() - 1, q_i[k], q_q[k]);
  endtask
  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0);
    repeat (n) @(posedge clk);
  endtask
  task automatic fill(input int n, input longint a, input longint b);
    q_i = {}; q_q = {};
    repeat (n) begin q_i.push_back(a); q_q.push_back(b); end
  endtask
  task automatic clear;
    push_q = {}; err_q = {};
  endtask
  task automatic test_reset;
    rst = 1'b1;
    bus.prod_vld = 0; bus.prod_first = 0; bus.prod_last = 0; bus.prod_i = '0; bus.prod_q = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.PushOut, bus.FI, bus.FQ, bus.tap_err, bus.sat_flag} !== 67'd0) begin
      failures++;
      $display("FAIL reset_outputs: got push=%b FI=%h FQ=%h err=%b sat=%b, expected all zero",
               bus.PushOut, bus.FI, bus.FQ, bus.tap_err, bus.sat_flag);
    end
    rst = 1'b0;
    clear;
  endtask
  task automatic test_basic;
    clear; fill(29, P19, -P19); send; idle(5);
    checks++;
    if (push_q.size() !== 1) begin failures++; $display("FAIL basic_push_count: got %0d expected 1", push_q.size()); end
    if (push_q.size() == 1) begin
      checks++;
      if (push_q[0].c !== last_cyc + 2) begin failures++; $display("FAIL basic_latency: got cycle %0d expected %0d", push_q[0].c, last_cyc + 2); end
      checks++;
      if ({push_q[0].i, push_q[0].q, push_q[0].s} !== {32'd29, 32'hFFFF_FFE3, 1'b0}) begin
        failures++; $display("FAIL basic_value: got FI=%h FQ=%h sat=%b expected FI=0000001d FQ=ffffffe3 sat=0", push_q[0].i, push_q[0].q, push_q[0].s);
      end
    end
    checks++;
    if (err_q.size() !== 0) begin failures++; $display("FAIL basic_tap_err: got %0d pulses expected 0", err_q.size()); end
    @(negedge clk);
    checks++;
    if ({bus.PushOut, bus.FI} !== {1'b0, 32'd29}) begin failures++; $display("FAIL basic_hold: got push=%b FI=%h expected push=0 FI=0000001d", bus.PushOut, bus.FI); end
  endtask
  task automatic test_round;
    clear; fill(1, P19 / 2, -P19 / 2); send; idle(5);
    checks++;
    if (push_q.size() !== 1 || {push_q[0].i, push_q[0].q} !== {32'd1, 32'd0}) begin
      failures++; $display("FAIL round_half_up: got count=%0d FI=%h FQ=%h expected 1 FI=1 FQ=0", push_q.size(), bus.FI, bus.FQ);
    end
    checks++;
    if (err_q.size() !== 1 || err_q[0] !== last_cyc + 1) begin
      failures++; $display("FAIL round_tap_err: got %0d pulses expected one at cycle %0d", err_q.size(), last_cyc + 1);
    end
  endtask
  task automatic test_sat;
    logic [32:0] ex;
`ifdef FIR_ACCUM_SAT_EN
    ex = {1'b1, 32'h7FFF_FFFF};
`else
    ex = {1'b0, 32'h4000_0000};
`endif
    clear; fill(29, 64'sd1 <<< 49, 0); send; idle(5);
    checks++;
    if (push_q.size() !== 1 || {push_q[0].s, push_q[0].i, push_q[0].q} !== {ex, 32'd0}) begin
      failures++; $display("FAIL sat_value: got count=%0d FI=%h sat=%b expected FI=%h sat=%b", push_q.size(), bus.FI, bus.sat_flag, ex[31:0], ex[32]);
    end
  endtask
  task automatic test_short;
    logic [32:0] mi, mq;
    clear; q_i = {}; q_q = {};
    repeat (6) begin q_i.push_back(rnd(40)); q_q.push_back(rnd(40)); end
    send; idle(5);
    mi = model(qsum(0)); mq = model(qsum(1));
    checks++;
    if (err_q.size() !== 1 || err_q[0] !== last_cyc + 1) begin
      failures++; $display("FAIL short_tap_err: got %0d pulses expected one at cycle %0d", err_q.size(), last_cyc + 1);
    end
    checks++;
    if (push_q.size() !== 1 || {push_q[0].c, push_q[0].i, push_q[0].q} !== {last_cyc + 2, mi[31:0], mq[31:0]}) begin
      failures++; $display("FAIL short_value: got count=%0d FI=%h FQ=%h expected FI=%h FQ=%h", push_q.size(), bus.FI, bus.FQ, mi[31:0], mq[31:0]);
    end
  endtask
  task automatic test_stray;
    int c1, c2;
    clear;
    drive(1, 0, 0, P19, P19); c1 = cyc;
    drive(1, 0, 1, P19, P19); c2 = cyc;
    drive(0, 1, 1, P19, P19);
    idle(5);
    checks++;
    if (err_q.size() !== 2 || err_q[0] !== c1 + 1 || err_q[1] !== c2 + 1) begin
      failures++; $display("FAIL stray_tap_err: got %0d pulses expected 2 at cycles %0d,%0d", err_q.size(), c1 + 1, c2 + 1);
    end
    checks++;
    if (push_q.size() !== 0) begin failures++; $display("FAIL stray_push: got %0d pushes expected 0", push_q.size()); end
  endtask
  task automatic test_restart;
    clear;
    drive(1, 1, 0, rnd(45), rnd(45));
    repeat (4) drive(1, 0, 0, rnd(45), rnd(45));
    fill(29, P19, P19); send; idle(5);
    checks++;
    if (err_q.size() !== 1 || err_q[0] !== last_cyc - 27) begin
      failures++; $display("FAIL restart_tap_err: got %0d pulses expected one at cycle %0d", err_q.size(), last_cyc - 27);
    end
    checks++;
    if (push_q.size() !== 1 || {push_q[0].i, push_q[0].q} !== {32'd29, 32'd29}) begin
      failures++; $display("FAIL restart_value: got count=%0d FI=%h FQ=%h expected 1d 1d", push_q.size(), bus.FI, bus.FQ);
    end
  endtask
  task automatic test_back_to_back;
    int l1;
    clear;
    fill(29, P19, -P19); send; l1 = last_cyc;
    fill(29, 2 * P19, -2 * P19); send; idle(5);
    checks++;
    if (push_q.size() !== 2) begin failures++; $display("FAIL b2b_count: got %0d expected 2", push_q.size()); end
    if (push_q.size() == 2) begin
      checks++;
      if ({push_q[0].c, push_q[0].i, push_q[0].q} !== {l1 + 2, 32'd29, 32'hFFFF_FFE3}) begin
        failures++; $display("FAIL b2b_first: got cycle %0d FI=%h FQ=%h expected cycle %0d FI=1d FQ=ffffffe3", push_q[0].c, push_q[0].i, push_q[0].q, l1 + 2);
      end
      checks++;
      if ({push_q[1].c, push_q[1].i, push_q[1].q} !== {last_cyc + 2, 32'd58, 32'hFFFF_FFC6}) begin
        failures++; $display("FAIL b2b_second: got cycle %0d FI=%h FQ=%h expected cycle %0d FI=3a FQ=ffffffc6", push_q[1].c, push_q[1].i, push_q[1].q, last_cyc + 2);
      end
    end
    checks++;
    if (err_q.size() !== 0) begin failures++; $display("FAIL b2b_tap_err: got %0d pulses expected 0", err_q.size()); end
  endtask
  task automatic test_rst_mid;
    clear;
    fill(10, P19, P19);
    for (int k = 0; k < 10; k++) drive(1, k == 0, 0, q_i[k], q_q[k]);
    @(posedge clk); #1;
    rst = 1'b1; bus.prod_vld = 0; bus.prod_first = 0; bus.prod_last = 0;
    @(negedge clk);
    checks++;
    if ({bus.PushOut, bus.FI, bus.FQ, bus.tap_err} !== 66'd0) begin
      failures++; $display("FAIL rst_mid_outputs: got push=%b FI=%h FQ=%h err=%b expected all zero", bus.PushOut, bus.FI, bus.FQ, bus.tap_err);
    end
    @(posedge clk); #1; rst = 1'b0;
    fill(29, P19, P19); send; idle(5);
    checks++;
    if (push_q.size() !== 1 || {push_q[0].c, push_q[0].i} !== {last_cyc + 2, 32'd29}) begin
      failures++; $display("FAIL rst_mid_value: got count=%0d FI=%h expected one push FI=1d", push_q.size(), bus.FI);
    end
    checks++;
    if (err_q.size() !== 0) begin failures++; $display("FAIL rst_mid_tap_err: got %0d pulses expected 0", err_q.size()); end
  endtask
  task automatic test_random;
    ev_t exp_q[$];
    int exp_err[$];
    logic [32:0] mi, mq;
    clear;
    for (int s = 0; s < 10; s++) begin
      int n;
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 35)) : 29;
      q_i = {}; q_q = {};
      repeat (n) begin q_i.push_back(rnd($urandom_range(10, 50))); q_q.push_back(rnd($urandom_range(10, 50))); end
      send;
      mi = model(qsum(0)); mq = model(qsum(1));
      exp_q.push_back('{last_cyc + 2, mi[31:0], mq[31:0], mi[32] | mq[32]});
      if (n != 29) exp_err.push_back(last_cyc + 1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 2));
    end
    idle(5);
    checks++;
    if (push_q.size() !== exp_q.size()) begin failures++; $display("FAIL rand_count: got %0d expected %0d", push_q.size(), exp_q.size()); end
    foreach (exp_q[k]) if (k < push_q.size()) begin
      checks++;
      if ({push_q[k].c, push_q[k].i, push_q[k].q, push_q[k].s} !== {exp_q[k].c, exp_q[k].i, exp_q[k].q, exp_q[k].s}) begin
        failures++; $display("FAIL rand_sample%0d: got cycle %0d FI=%h FQ=%h sat=%b expected cycle %0d FI=%h FQ=%h sat=%b",
                             k, push_q[k].c, push_q[k].i, push_q[k].q, push_q[k].s, exp_q[k].c, exp_q[k].i, exp_q[k].q, exp_q[k].s);
      end
    end
    checks++;
    if (err_q.size() !== exp_err.size()) begin failures++; $display("FAIL rand_err_count: got %0d expected %0d", err_q.size(), exp_err.size()); end
    foreach (exp_err[k]) if (k < err_q.size()) begin
      checks++;
      if (err_q[k] !== exp_err[k]) begin failures++; $display("FAIL rand_err%0d: got cycle %0d expected %0d", k, err_q[k], exp_err[k]); end
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_round;
    test_sat;
    test_short;
    test_stray;
    test_restart;
    test_back_to_back;
    test_rst_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fir_accum.md
FIR_ACCUM -- requirements
Module: fir_accum

Interface
REQ-001 SHALL have parameter NUM_TAPS, default 29, meaning products per output sample.
REQ-002 SHALL have parameter OUT_SHIFT, default 19, meaning the right-shift applied before 32-bit output.
REQ-003 SHALL have parameter ACC_W, default 56, meaning the accumulator width (51 + 5 guard bits).
REQ-004 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports: prod_vld  in  1  product valid; prod_first  in  1  first tap of sample; prod_last  in  1  last tap of sample.
REQ-006 SHALL have ports: prod_i  in  51  signed real product; prod_q  in  51  signed imaginary product (from the complex multiplier).
REQ-007 SHALL have ports: PushOut  out  1  output valid pulse; FI  out  32  signed real result; FQ  out  32  signed imaginary result.
REQ-008 SHALL have ports: tap_err  out  1  sequencing error pulse; sat_flag  out  1  clip indicator, valid with PushOut.

Function
REQ-009 SHALL implement the FSM states IDLE and ACCUM; prod_first/prod_last SHALL be ignored when prod_vld=0.
REQ-010 IDLE + vld&first&!last: acc_i/acc_q <= sign-extended product, tap_cnt <= 1, next state ACCUM.
REQ-011 IDLE + vld&!first: product discarded, tap_err=1 for one cycle, state unchanged.
REQ-012 ACCUM + vld&!first&!last: acc += product (ACC_W, two's complement), tap_cnt += 1.
REQ-013 ACCUM + vld&first: partial sum discarded, tap_err pulse, accumulator reloaded as in REQ-010.
REQ-014 vld&last (ACCUM, or IDLE with first): final sum = acc + product (product alone when first=1) SHALL be registered into a final-sum stage, and the FSM SHALL return to IDLE.
REQ-015 At last, if the resulting tap count != NUM_TAPS, tap_err SHALL pulse and the output SHALL still be produced.
REQ-016 The final-sum stage SHALL be independent of acc, so that prod_first is accepted in the cycle immediately after prod_last with no bubble.
REQ-017 Latency SHALL be: prod_last in cycle N -> PushOut=1 in cycle N+2 for exactly one cycle.
REQ-018 Rounding SHALL compute (sum + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT in ACC_W+1 bits (round half up).
REQ-019 FI/FQ SHALL hold their last value while PushOut=0.
REQ-020 sat_flag SHALL equal the OR of the I and Q clip conditions, qualified by PushOut; it SHALL be 0 when saturation is compiled out.

Reset
REQ-021 rst SHALL force state IDLE, with acc, tap_cnt, final-sum stage, PushOut, FI, FQ, tap_err and sat_flag all 0.
REQ-022 rst asserted mid-sample SHALL discard the partial sum and any in-flight result, producing no PushOut.
REQ-023 After rst deasserts, the first product SHALL be accepted on the next rising clk edge.

Configuration
REQ-024 Macro FIR_ACCUM_SAT_EN defined: the rounded value SHALL be clamped to [0x80000000, 0x7FFFFFFF] and sat_flag driven per REQ-020.
REQ-025 Macro FIR_ACCUM_SAT_EN undefined: the low 32 bits of the rounded value SHALL be output (wrap), and sat_flag SHALL be tied to 0.

Structure
REQ-026 Package fir_pkg SHALL hold NUM_TAPS, the product/accumulator/output width constants and the FSM state enum, shared with firc.
REQ-027 Sub-module fir_round_sat (round + optional saturate, 1 register stage) SHALL be instantiated twice, once for I and once for Q.

Verification
REQ-028 29 taps, prod_i=2^19, prod_q=-2^19 -> PushOut at last+2, FI=29, FQ=-29, tap_err=0, sat_flag=0.
REQ-029 Single vld&first&last, prod_i=2^18, prod_q=-2^18 -> FI=1, FQ=0 (round half up).
REQ-030 29 taps, prod_i=2^49 -> SAT_EN: FI=0x7FFFFFFF, sat_flag=1; without SAT_EN: FI=0x40000000, sat_flag=0.
REQ-031 first + 4 taps + last (6 total) -> tap_err pulse at last, PushOut still issued with FI equal to the rounded sum.
REQ-032 Two samples back-to-back (second first one cycle after last), 29 taps of 2^19 then 29 taps of 2*2^19 -> FI=29 then 58, with no lost product.
REQ-033 rst pulse at tap 10, then a fresh 29-tap sample of 2^19 -> no PushOut for the aborted sample, then FI=29.
